// File: rtl/frame_dump_ctrl.sv
// frame_dump_ctrl: frame-windowed capture controller.
// It counts completed frames on falling edges of vertical sync. It arms
// either just after reset or when a ROM download finishes. Once armed, it
// raises a per-channel dump enable for a programmable window of frames.
module frame_dump_ctrl #(
  parameter int CH           = 4,
  parameter int FW           = 32,
  parameter int LW           = 16,
  parameter int ARM_ON_DWNLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs,
  input  logic             dwnld,
  input  logic             trig,
  input  logic [CH*FW-1:0] start_frame,
  input  logic [CH*LW-1:0] len_frames,
  output logic [FW-1:0]    frame_cnt,
  output logic             armed,
  output logic [CH-1:0]    dump_en,
  output logic [CH-1:0]    dump_on,
  output logic [CH-1:0]    dump_off,
  output logic             all_done
);

  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DONE} ch_state_t;

  ch_state_t     state [CH];
  logic [LW-1:0] rem   [CH];   // frames left in window; 0 means unlimited

  logic          vs_l;
  logic          dwnld_l;
  logic          arm_pend;     // one-shot arming request left behind by reset
  logic          vs_fall;
  logic          dwnld_fall;
  logic          dwnld_rise;
  logic          disarm;
  logic          arm_evt;
  logic [CH-1:0] len_nz;
  logic          done_ok;

  assign vs_fall    = vs_l & ~vs;
  assign dwnld_fall = dwnld_l & ~dwnld;
  assign dwnld_rise = ~dwnld_l & dwnld;
  assign disarm     = armed & dwnld_rise;
  assign arm_evt    = ~armed & ((ARM_ON_DWNLD != 0) ? dwnld_fall : arm_pend);

  // Completion qualifier: every channel with a finite window has finished.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    len_nz  = '0;
    done_ok = 1'b1;
    for (int i = 0; i < CH; i++) begin
      len_nz[i] = |len_frames[i*LW +: LW];
      if (len_nz[i] && (state[i] != DONE)) done_ok = 1'b0;
    end
  end

  // Edge capture, arming, frame counting and the per-channel window FSMs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      vs_l      <= 1'b0;
      dwnld_l   <= 1'b0;
      arm_pend  <= 1'b1;
      armed     <= 1'b0;
      frame_cnt <= '0;
      dump_en   <= '0;
      dump_on   <= '0;
      dump_off  <= '0;
      all_done  <= 1'b0;
      // NOTE: the small per-channel arrays are reset explicitly. They are
      // flops, not RAM, and IDLE must be guaranteed out of reset.
      for (int i = 0; i < CH; i++) begin
        state[i] <= IDLE;
        rem[i]   <= '0;
      end
    end else begin
      vs_l     <= vs;
      dwnld_l  <= dwnld;
      dump_on  <= '0;
      dump_off <= '0;
      all_done <= (|len_nz) & done_ok;

      if (disarm) begin
        // A new download aborts everything; running windows close cleanly.
        armed     <= 1'b0;
        frame_cnt <= '0;
        all_done  <= 1'b0;
        for (int i = 0; i < CH; i++) begin
          if (state[i] == ACTIVE) dump_off[i] <= 1'b1;
          dump_en[i] <= 1'b0;
          state[i]   <= IDLE;
        end
      end else if (arm_evt) begin
        armed     <= 1'b1;
        arm_pend  <= 1'b0;
        frame_cnt <= '0;
        for (int i = 0; i < CH; i++) state[i] <= WAIT;
      end else if (armed) begin
        if (vs_fall && (frame_cnt != '1)) frame_cnt <= frame_cnt + 1'b1;

        for (int i = 0; i < CH; i++) begin
          case (state[i])
            WAIT: begin
              // Start frame matches by equality only; a missed start never fires.
              if (trig || (vs_fall && (frame_cnt == start_frame[i*FW +: FW]))) begin
                state[i]   <= ACTIVE;
                rem[i]     <= len_frames[i*LW +: LW];
                dump_en[i] <= 1'b1;
                dump_on[i] <= 1'b1;
              end
            end
            ACTIVE: begin
              if (vs_fall && (rem[i] != '0)) begin
                if (rem[i] == LW'(1)) begin
                  state[i]    <= DONE;
                  dump_en[i]  <= 1'b0;
                  dump_off[i] <= 1'b1;
                end else begin
                  rem[i] <= rem[i] - 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Testbench for frame_dump_ctrl. It runs three instances: arm-after-reset,
// arm-on-download, and a narrow 4-bit frame counter. Expected dump_on and
// dump_off events are queued ahead of the stimulus. A monitor retires them
// as the DUT produces the matching pulses.
module tb_frame_dump_ctrl;

  localparam int CH  = 4;
  localparam int FW  = 32;
  localparam int LW  = 16;
  localparam int FW4 = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic vs    = 1'b0;
  logic dwnld = 1'b0;
  logic trig  = 1'b0;
  logic [CH*FW-1:0]  start_frame  = '0;
  logic [CH*FW4-1:0] start_frame4 = '1;
  logic [CH*LW-1:0]  len_frames   = '0;

  logic [FW-1:0]  fc0, fc1;
  logic [FW4-1:0] fc2;
  logic           armed0, armed1, armed2;
  logic [CH-1:0]  en0, on0, off0, en1, on1, off1, en2, on2, off2;
  logic           done0, done1, done2;

  typedef struct {
    int          ch;
    bit          on;
    logic [31:0] fc;
  } ev_t;

  ev_t sb [$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_sel  = 1'b0;   // 0: monitor dut0, 1: monitor dut1

  always #5 clk = ~clk;

  frame_dump_ctrl #(.CH(CH), .FW(FW), .LW(LW), .ARM_ON_DWNLD(0)) dut0 (
    .clk(clk), .rst(rst), .vs(vs), .dwnld(dwnld), .trig(trig),
    .start_frame(start_frame), .len_frames(len_frames),
    .frame_cnt(fc0), .armed(armed0), .dump_en(en0), .dump_on(on0),
    .dump_off(off0), .all_done(done0)
  );

  frame_dump_ctrl #(.CH(CH), .FW(FW), .LW(LW), .ARM_ON_DWNLD(1)) dut1 (
    .clk(clk), .rst(rst), .vs(vs), .dwnld(dwnld), .trig(trig),
    .start_frame(start_frame), .len_frames(len_frames),
    .frame_cnt(fc1), .armed(armed1), .dump_en(en1), .dump_on(on1),
    .dump_off(off1), .all_done(done1)
  );

  frame_dump_ctrl #(.CH(CH), .FW(FW4), .LW(LW), .ARM_ON_DWNLD(0)) dut2 (
    .clk(clk), .rst(rst), .vs(vs), .dwnld(dwnld), .trig(trig),
    .start_frame(start_frame4), .len_frames(len_frames),
    .frame_cnt(fc2), .armed(armed2), .dump_en(en2), .dump_on(on2),
    .dump_off(off2), .all_done(done2)
  );

  // Scoreboard monitor: each enable edge pulse must match the queue head.
  always @(negedge clk) begin
    logic [CH-1:0] on_v, off_v;
    logic [31:0]   fc_v;
    bit            hit;
    ev_t           e;
    on_v  = mon_sel ? on1  : on0;
    off_v = mon_sel ? off1 : off0;
    fc_v  = mon_sel ? fc1  : fc0;
    for (int i = 0; i < CH; i++) begin
      for (int k = 0; k < 2; k++) begin
        hit = (k == 0) ? on_v[i] : off_v[i];
        if (hit) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: ch%0d on=%0d at frame %0d, required no event",
                     i, (k == 0), fc_v);
          end else begin
            e = sb.pop_front();
            if (e.ch != i || e.on != (k == 0) || e.fc !== fc_v) begin
              n_fail++;
              $display("FAIL sb_event: got ch%0d on=%0d frame %0d, required ch%0d on=%0d frame %0d",
                       i, (k == 0), fc_v, e.ch, e.on, e.fc);
            end
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, required finish");
    $fatal(1, "watchdog");
  end

  task automatic set_ch(input int ch, input int s, input int l);
    start_frame[ch*FW +: FW] = FW'(s);
    len_frames[ch*LW +: LW]  = LW'(l);
  endtask

  task automatic set_all_idle();
    for (int i = 0; i < CH; i++) set_ch(i, 1000, 0);
  endtask

  task automatic push_ev(input int ch, input bit on, input int fc);
    ev_t e;
    e.ch = ch;
    e.on = on;
    e.fc = 32'(fc);
    sb.push_back(e);
  endtask

  task automatic vs_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) vs = 1'b1;
      @(negedge clk);
      @(negedge clk) vs = 1'b0;
      @(negedge clk);
    end
  endtask

  // Leaves the ARM_ON_DWNLD=0 instances armed with frame_cnt at 0.
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic sb_drain(input string name);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d expected events never seen, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    set_all_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (fc0 !== '0)     begin n_fail++; $display("FAIL rst_fc: got %0d, required 0", fc0); end
    n_checks++; if (armed0 !== 1'b0) begin n_fail++; $display("FAIL rst_armed: got %0b, required 0", armed0); end
    n_checks++; if (en0 !== '0 || on0 !== '0 || off0 !== '0)
      begin n_fail++; $display("FAIL rst_dump: got en=%h on=%h off=%h, required 0", en0, on0, off0); end
    n_checks++; if (done0 !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %0b, required 0", done0); end
    n_checks++; if (fc2 !== '0)     begin n_fail++; $display("FAIL rst_fc4: got %0d, required 0", fc2); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_checks++; if (armed0 !== 1'b1) begin n_fail++; $display("FAIL arm_after_rst: got %0b, required 1", armed0); end
    n_checks++; if (armed1 !== 1'b0) begin n_fail++; $display("FAIL dwnld_arm_idle: got %0b, required 0", armed1); end
    n_checks++; if (fc0 !== '0)     begin n_fail++; $display("FAIL arm_fc: got %0d, required 0", fc0); end
  endtask

  task automatic test_window();
    mon_sel = 1'b0;
    set_all_idle();
    set_ch(0, 3, 2);
    do_reset();
    push_ev(0, 1'b1, 4);
    push_ev(0, 1'b0, 6);
    vs_pulse(5);
    n_checks++; if (en0 !== 4'h1) begin n_fail++; $display("FAIL win_mid_en: got %h, required 1", en0); end
    vs_pulse(3);
    n_checks++; if (en0 !== 4'h0) begin n_fail++; $display("FAIL win_end_en: got %h, required 0", en0); end
    n_checks++; if (fc0 !== 32'd8) begin n_fail++; $display("FAIL win_fc: got %0d, required 8", fc0); end
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL win_done: got %0b, required 1", done0); end
    sb_drain("win");
  endtask

  task automatic test_unlimited();
    mon_sel = 1'b0;
    set_all_idle();
    set_ch(2, 5, 0);
    do_reset();
    push_ev(2, 1'b1, 6);
    vs_pulse(5);
    n_checks++; if (en0 !== 4'h0) begin n_fail++; $display("FAIL unl_early_en: got %h, required 0", en0); end
    vs_pulse(1);
    n_checks++; if (en0 !== 4'h4) begin n_fail++; $display("FAIL unl_start_en: got %h, required 4", en0); end
    vs_pulse(14);
    n_checks++; if (en0 !== 4'h4) begin n_fail++; $display("FAIL unl_hold_en: got %h, required 4", en0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL unl_done: got %0b, required 0", done0); end
    sb_drain("unl");
  endtask

  task automatic test_trig();
    mon_sel = 1'b0;
    set_all_idle();
    set_ch(0, 100, 3);
    do_reset();
    vs_pulse(1);
    for (int i = 0; i < CH; i++) push_ev(i, 1'b1, 1);
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
    n_checks++; if (en0 !== 4'hF) begin n_fail++; $display("FAIL trig_en: got %h, required f", en0); end
    push_ev(0, 1'b0, 4);
    vs_pulse(3);
    n_checks++; if (en0 !== 4'hE) begin n_fail++; $display("FAIL trig_end_en: got %h, required e", en0); end
    vs_pulse(101);
    n_checks++; if (en0 !== 4'hE) begin n_fail++; $display("FAIL trig_norestart: got %h, required e", en0); end
    n_checks++; if (fc0 !== 32'd105) begin n_fail++; $display("FAIL trig_fc: got %0d, required 105", fc0); end
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL trig_done: got %0b, required 1", done0); end
    sb_drain("trig");
  endtask

  task automatic test_dwnld_arm();
    mon_sel = 1'b1;
    set_all_idle();
    set_ch(0, 2, 0);
    set_ch(1, 0, 1);
    do_reset();
    n_checks++; if (armed1 !== 1'b0) begin n_fail++; $display("FAIL dl_pre_armed: got %0b, required 0", armed1); end
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk) dwnld = 1'b1;
      repeat (9) @(negedge clk);
      @(negedge clk) dwnld = 1'b0;
      n_checks++; if (armed1 !== 1'b0) begin n_fail++; $display("FAIL dl_arm_early: got %0b, required 0", armed1); end
      @(negedge clk);
      n_checks++; if (armed1 !== 1'b1) begin n_fail++; $display("FAIL dl_armed: got %0b, required 1", armed1); end
      push_ev(1, 1'b1, 1);
      push_ev(1, 1'b0, 2);
      push_ev(0, 1'b1, 3);
      vs_pulse(4);
      n_checks++; if (en1 !== 4'h1) begin n_fail++; $display("FAIL dl_en: got %h, required 1", en1); end
      n_checks++; if (fc1 !== 32'd4) begin n_fail++; $display("FAIL dl_fc: got %0d, required 4", fc1); end
      n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL dl_done: got %0b, required 1", done1); end
      if (pass == 0) begin
        // A new download while ch0 is running closes its window at once.
        push_ev(0, 1'b0, 0);
        @(negedge clk) dwnld = 1'b1;
        @(negedge clk);
        n_checks++; if (off1 !== 4'h1) begin n_fail++; $display("FAIL dis_off: got %h, required 1", off1); end
        n_checks++; if (en1 !== 4'h0) begin n_fail++; $display("FAIL dis_en: got %h, required 0", en1); end
        n_checks++; if (armed1 !== 1'b0) begin n_fail++; $display("FAIL dis_armed: got %0b, required 0", armed1); end
        n_checks++; if (fc1 !== '0) begin n_fail++; $display("FAIL dis_fc: got %0d, required 0", fc1); end
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL dis_done: got %0b, required 0", done1); end
        @(negedge clk) dwnld = 1'b0;
        @(negedge clk);
      end
    end
    sb_drain("dl");
  endtask

  task automatic test_reset_mid();
    mon_sel = 1'b0;
    set_all_idle();
    set_ch(0, 1, 5);
    do_reset();
    push_ev(0, 1'b1, 2);
    vs_pulse(3);
    n_checks++; if (en0 !== 4'h1) begin n_fail++; $display("FAIL rmid_en_pre: got %h, required 1", en0); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    n_checks++; if (en0 !== '0 || on0 !== '0 || off0 !== '0)
      begin n_fail++; $display("FAIL rmid_dump: got en=%h on=%h off=%h, required 0", en0, on0, off0); end
    n_checks++; if (armed0 !== 1'b0 || fc0 !== '0 || done0 !== 1'b0)
      begin n_fail++; $display("FAIL rmid_state: got armed=%0b fc=%0d done=%0b, required 0", armed0, fc0, done0); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    sb_drain("rmid");
  endtask

  task automatic test_saturate();
    mon_sel = 1'b0;
    set_all_idle();
    do_reset();
    vs_pulse(14);
    n_checks++; if (fc2 !== 4'd14) begin n_fail++; $display("FAIL sat_below: got %0d, required 14", fc2); end
    vs_pulse(6);
    n_checks++; if (fc2 !== 4'd15) begin n_fail++; $display("FAIL sat_fc4: got %0d, required 15", fc2); end
    n_checks++; if (fc0 !== 32'd20) begin n_fail++; $display("FAIL sat_fc32: got %0d, required 20", fc0); end
    sb_drain("sat");
  endtask

  initial begin
    test_reset();
    test_window();
    test_unlimited();
    test_trig();
    test_dwnld_arm();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
